// File: rtl/onchip_memory_pkg.sv
// Shared definitions for the pipelined on-chip memory.
// Holds the Avalon response codes, the clear-FSM state type, the legal
// read-latency range and a helper that sizes the RAM's internal address.
package onchip_memory_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_e;

  // Bits needed to index DEPTH words (at least one).
  function automatic int ram_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/onchip_memory_ram_core.sv
// Inferred single-port RAM with byte-lane write enables and a registered
// read port. A read and write to the same word on one edge returns the
// pre-write contents. Both ports advance only while ce=1.
// Ports:
//   clk    - clock
//   ce     - clock enable for read register and write
//   we/re  - write / read strobe
//   addr   - word address (AW bits)
//   be     - byte-lane write enables
//   wdata  - write data
//   rdata  - registered read data (holds when not reading)
module onchip_memory_ram_core #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 12288,
  parameter int    AW        = 14,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                ce,
  input  logic                we,
  input  logic                re,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (re) rdata <= mem[addr];
      if (we) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/onchip_memory_pipelined.sv
// Avalon-MM on-chip memory with 1- or 2-cycle pipelined reads.
// Out-of-range reads answer SLVERR with zero data; out-of-range writes are
// dropped. clken=0 freezes the whole pipe and raises waitrequest.
// Optional macro ONCHIP_MEM_CLEAR_EN: after reset a CLEAR->IDLE FSM zeroes
// every word (one per enabled cycle) while holding waitrequest high.
// Ports:
//   clk, reset_n           - clock, async active-low reset
//   address, byteenable    - word address, write byte lanes
//   chipselect/read/write  - request qualifiers
//   writedata              - write data
//   clken                  - clock enable (0 = stall)
//   readdata, readdatavalid, response - read return
//   waitrequest            - request not accepted this cycle
module onchip_memory_pipelined
  import onchip_memory_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    DEPTH        = 12288,
  parameter int    ADDR_W       = 14,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic [1:0]          response,
  output logic                waitrequest
);

  localparam int LAT = (READ_LATENCY < MIN_READ_LATENCY) ? MIN_READ_LATENCY :
                       (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                       READ_LATENCY;
  localparam int RAM_AW = ram_aw(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic in_range, clearing, busy, acc, wr_acc, rd_acc;
  logic ram_we, ram_re;
  logic [RAM_AW-1:0]   ram_addr;
  logic [DATA_W/8-1:0] ram_be;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata, rd_data;

  // Extra leading zero so DEPTH == 2**ADDR_W compares correctly.
  assign in_range = {1'b0, address} < DEPTH_LIM;

  // Reset wins over the stall indication so waitrequest reads 0 in reset.
  assign busy        = !clken || clearing;
  assign waitrequest = reset_n && busy;
  assign acc         = reset_n && chipselect && (read || write) && !busy;
  assign wr_acc      = acc && write && in_range;
  assign rd_acc      = acc && read && !write;
  assign ram_re      = rd_acc && in_range;

`ifdef ONCHIP_MEM_CLEAR_EN
  localparam logic [RAM_AW-1:0] LAST = RAM_AW'(DEPTH - 1);

  clr_state_e        state;
  logic [RAM_AW-1:0] clr_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (clken && state == ST_CLEAR) begin
      if (clr_addr == LAST) state <= ST_IDLE;
      else                  clr_addr <= clr_addr + 1'b1;
    end
  end

  assign clearing  = (state == ST_CLEAR);
  assign ram_we    = reset_n && (clearing ? clken : wr_acc);
  assign ram_addr  = clearing ? clr_addr : address[RAM_AW-1:0];
  assign ram_be    = clearing ? '1 : byteenable;
  assign ram_wdata = clearing ? '0 : writedata;
`else
  assign clearing  = 1'b0;
  assign ram_we    = wr_acc;
  assign ram_addr  = address[RAM_AW-1:0];
  assign ram_be    = byteenable;
  assign ram_wdata = writedata;
`endif

  onchip_memory_ram_core #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AW        (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .ce    (clken),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Stage s holds the read accepted s enabled cycles ago.
  logic [LAT:1] vld_pipe, oor_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      oor_pipe <= '0;
    end else if (clken) begin
      vld_pipe[1] <= rd_acc;
      oor_pipe[1] <= !in_range;
      for (int s = 2; s <= LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        oor_pipe[s] <= oor_pipe[s-1];
      end
    end
  end

  if (LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (clken) rdata_q <= ram_rdata;
    end
    assign rd_data = rdata_q;
  end else begin : g_lat1
    assign rd_data = ram_rdata;
  end

  // Data is masked outside a valid beat, which also gives zeros in reset.
  assign readdatavalid = vld_pipe[LAT] && clken;
  assign readdata      = (vld_pipe[LAT] && !oor_pipe[LAT]) ? rd_data : '0;
  assign response      = (vld_pipe[LAT] && oor_pipe[LAT]) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Directed bench: two instances (READ_LATENCY 1 and 2) share the request
// bus. A negedge monitor logs every read beat with its cycle stamp; tests
// queue the expected beats and compare after a drain window.
module tb_onchip_memory_pipelined;
  import onchip_memory_pkg::*;

`ifdef ONCHIP_MEM_CLEAR_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 12288;
`endif
  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;

  logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, read = 1'b0, write = 1'b0, clken = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic [3:0]        byteenable = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata1, readdata2;
  logic              rdv1, rdv2, wr1, wr2;
  logic [1:0]        resp1, resp2;

  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  onchip_memory_pipelined #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(readdata1), .readdatavalid(rdv1), .response(resp1),
    .waitrequest(wr1));

  onchip_memory_pipelined #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(readdata2), .readdatavalid(rdv2), .response(resp2),
    .waitrequest(wr2));

  typedef struct { logic [31:0] d; logic [1:0] r; int c; } beat_t;
  beat_t got1[$], got2[$], exp1[$], exp2[$];

  always @(negedge clk) begin
    if (rdv1) got1.push_back('{readdata1, resp1, cyc});
    if (rdv2) got2.push_back('{readdata2, resp2, cyc});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    address = ADDR_W'(a); writedata = d; byteenable = be;
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    tick(); idle();
  endtask

  // extra = enabled-cycle stall expected between accept and the beat
  task automatic rd(input int a, input logic [31:0] d, input logic [1:0] r, input int extra);
    address = ADDR_W'(a); chipselect = 1'b1; read = 1'b1; write = 1'b0;
    exp1.push_back('{d, r, cyc + 1 + extra});
    exp2.push_back('{d, r, cyc + 2 + extra});
    tick(); idle();
  endtask

  task automatic drain(input string tag);
    tick(6);
    chk({tag, "_cnt1"}, got1.size(), exp1.size());
    chk({tag, "_cnt2"}, got2.size(), exp2.size());
    foreach (exp1[i]) if (i < got1.size()) begin
      chk({tag, "_data1"}, got1[i].d, exp1[i].d);
      chk({tag, "_resp1"}, got1[i].r, exp1[i].r);
      chk({tag, "_cyc1"},  got1[i].c, exp1[i].c);
    end
    foreach (exp2[i]) if (i < got2.size()) begin
      chk({tag, "_data2"}, got2[i].d, exp2[i].d);
      chk({tag, "_resp2"}, got2[i].r, exp2[i].r);
      chk({tag, "_cyc2"},  got2[i].c, exp2[i].c);
    end
    got1.delete(); got2.delete(); exp1.delete(); exp2.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdata1"}, readdata1, 0); chk({tag, "_rdata2"}, readdata2, 0);
    chk({tag, "_rdv1"},   rdv1, 0);      chk({tag, "_rdv2"},   rdv2, 0);
    chk({tag, "_resp1"},  resp1, RESP_OKAY); chk({tag, "_resp2"}, resp2, RESP_OKAY);
    chk({tag, "_wreq1"},  wr1, 0);       chk({tag, "_wreq2"},  wr2, 0);
  endtask

  task automatic release_rst();
`ifdef ONCHIP_MEM_CLEAR_EN
    int n;
    reset_n = 1'b1;
    #1;
    n = 0;
    while (wr2 && n < 200) begin
      n++;
      tick();
    end
    chk("clear_len", n, DEPTH);
`else
    reset_n = 1'b1;
    #1;
    chk("wreq_after_rst", wr2, 0);
`endif
  endtask

  initial begin
    // reset state
    reset_n = 1'b0;
    tick(2);
    chk_reset_outs("rst");
    release_rst();

    // byte-lane merge, read right after write sees new data
    wr(5, 32'h1122_3344, 4'hF);
    wr(5, 32'hDEAD_BEEF, 4'b0011);
    rd(5, 32'h1122_BEEF, RESP_OKAY, 0);
    drain("be_merge");

    // back-to-back reads, in order, fixed latency
    wr(0, 32'hA0A0_0000, 4'hF);
    wr(1, 32'hA1A1_0001, 4'hF);
    wr(2, 32'hA2A2_0002, 4'hF);
    rd(0, 32'hA0A0_0000, RESP_OKAY, 0);
    rd(1, 32'hA1A1_0001, RESP_OKAY, 0);
    rd(2, 32'hA2A2_0002, RESP_OKAY, 0);
    drain("b2b");

    // out-of-range: write dropped, read errors with zero data
    wr(DEPTH, 32'hFFFF_FFFF, 4'hF);
    rd(DEPTH, 32'h0, RESP_SLVERR, 0);
    rd(16383, 32'h0, RESP_SLVERR, 0);
    drain("oor");

    // read+write together acts as write only
    address = ADDR_W'(7); writedata = 32'h0000_0777; byteenable = 4'hF;
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    tick(); idle();
    rd(7, 32'h0000_0777, RESP_OKAY, 0);
    drain("rw_both");

    // three stalled cycles with a read in flight; request during stall ignored
    rd(1, 32'hA1A1_0001, RESP_OKAY, 3);
    clken = 1'b0;
    address = ADDR_W'(2); chipselect = 1'b1; read = 1'b1;
    #1;
    chk("wreq_stall", wr2, 1);
    chk("rdv_stall", rdv1, 0);
    tick(3);
    idle();
    clken = 1'b1;
    drain("stall");

    // reset with two reads in flight: only the already-delivered beat remains
    address = ADDR_W'(0); chipselect = 1'b1; read = 1'b1;
    exp1.push_back('{32'hA0A0_0000, RESP_OKAY, cyc + 1});
    tick();
    address = ADDR_W'(1);
    tick();
    idle();
    reset_n = 1'b0;
    #1;
    chk_reset_outs("rst_flight");
    tick(2);
    release_rst();
    chk_reset_outs("post_rst");
    drain("rst_flight");

`ifdef ONCHIP_MEM_CLEAR_EN
    // reset mid-clear restarts the sweep, then every word reads zero
    wr(3, 32'h3333_3333, 4'hF);
    wr(15, 32'hFFFF_0000, 4'hF);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(8);
    chk("clear_mid_wreq", wr2, 1);
    reset_n = 1'b0;
    tick();
    release_rst();
    for (int a = 0; a < DEPTH; a++) rd(a, 32'h0, RESP_OKAY, 0);
    drain("cleared");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
